// File: rtl/wb_bus_arbiter.sv
// Two-master, one-slave Wishbone arbiter: m0 = instruction bus, m1 = data bus.
// Round-robin on ties, whole bus cycles are never split, and a watchdog turns a lost ack into err.
module wb_bus_arbiter #(
  parameter int N_ADDR      = 32,
  parameter int N_DATA      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N_ADDR-1:0]   i_m0_addr,
  input  logic [N_DATA-1:0]   i_m0_data,
  input  logic                i_m0_we,
  input  logic [N_DATA/8-1:0] i_m0_sel,
  input  logic                i_m0_stb,
  input  logic                i_m0_cyc,
  input  logic [N_ADDR-1:0]   i_m1_addr,
  input  logic [N_DATA-1:0]   i_m1_data,
  input  logic                i_m1_we,
  input  logic [N_DATA/8-1:0] i_m1_sel,
  input  logic                i_m1_stb,
  input  logic                i_m1_cyc,
  output logic [N_DATA-1:0]   o_m0_data,
  output logic                o_m0_ack,
  output logic                o_m0_err,
  output logic [N_DATA-1:0]   o_m1_data,
  output logic                o_m1_ack,
  output logic                o_m1_err,
  output logic [N_ADDR-1:0]   o_s_addr,
  output logic [N_DATA-1:0]   o_s_data,
  output logic                o_s_we,
  output logic [N_DATA/8-1:0] o_s_sel,
  output logic                o_s_stb,
  output logic                o_s_cyc,
  input  logic [N_DATA-1:0]   i_s_data,
  input  logic                i_s_ack,
  output logic [1:0]          o_grant
);

  // Handshake: a beat is offered while cyc & stb are high and completes in the cycle ack (or err)
  // is high; cyc framing a burst is owned end to end, and dropping cyc abandons any pending beat.
  localparam int WDW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M0 = 2'd1,
    OWN_M1 = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           last_owner_q, last_owner_d;
  logic [WDW-1:0] wdog_q, wdog_d;

  logic own_m0, own_m1;
  logic owner_stb;
  logic timeout_hit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      wdog_q       <= wdog_d;
    end
  end

  // Next-state: last_owner points at the loser-to-be of the next tie.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (i_m0_cyc && i_m1_cyc) state_d = last_owner_q ? OWN_M0 : OWN_M1;
        else if (i_m0_cyc)        state_d = OWN_M0;
        else if (i_m1_cyc)        state_d = OWN_M1;
      end
      OWN_M0:  if (!i_m0_cyc) state_d = IDLE;
      OWN_M1:  if (!i_m1_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == OWN_M0 && state_q != OWN_M0) last_owner_d = 1'b0;
    if (state_d == OWN_M1 && state_q != OWN_M1) last_owner_d = 1'b1;
  end

  assign own_m0    = (state_q == OWN_M0);
  assign own_m1    = (state_q == OWN_M1);
  assign owner_stb = (own_m0 && i_m0_stb && i_m0_cyc) || (own_m1 && i_m1_stb && i_m1_cyc);

  assign timeout_hit = (TIMEOUT_CYC != 0) && (wdog_q == WDW'(TIMEOUT_CYC - 1))
                       && owner_stb && !i_s_ack;

  // The counter runs on the owner's raw strobe so the forced-low stb on timeout cannot feed back.
  always_comb begin
    wdog_d = '0;
    if ((TIMEOUT_CYC != 0) && (state_d == state_q) && owner_stb && !i_s_ack && !timeout_hit)
      wdog_d = wdog_q + WDW'(1);
  end

  always_comb begin
    o_s_addr = '0;
    o_s_data = '0;
    o_s_we   = 1'b0;
    o_s_sel  = '0;
    o_s_cyc  = 1'b0;
    case (state_q)
      OWN_M0: begin
        o_s_addr = i_m0_addr;
        o_s_data = i_m0_data;
        o_s_we   = i_m0_we;
        o_s_sel  = i_m0_sel;
        o_s_cyc  = i_m0_cyc;
      end
      OWN_M1: begin
        o_s_addr = i_m1_addr;
        o_s_data = i_m1_data;
        o_s_we   = i_m1_we;
        o_s_sel  = i_m1_sel;
        o_s_cyc  = i_m1_cyc;
      end
      default: ;
    endcase
  end

  assign o_s_stb = owner_stb && !timeout_hit;

  assign o_m0_ack  = i_s_ack && own_m0 && !timeout_hit;
  assign o_m1_ack  = i_s_ack && own_m1 && !timeout_hit;
  assign o_m0_err  = timeout_hit && own_m0;
  assign o_m1_err  = timeout_hit && own_m1;
  assign o_m0_data = own_m0 ? i_s_data : '0;
  assign o_m1_data = own_m1 ? i_s_data : '0;

  assign o_grant = {own_m1, own_m0};

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: a per-cycle vector table for arbitration and reads,
// plus hand-written sequences for burst ownership, watchdog timeout and async reset.
module tb_wb_bus_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_m0_addr, i_m0_data, i_m1_addr, i_m1_data;
  logic        i_m0_we, i_m0_stb, i_m0_cyc, i_m1_we, i_m1_stb, i_m1_cyc;
  logic [3:0]  i_m0_sel, i_m1_sel;
  logic [31:0] o_m0_data, o_m1_data, o_s_addr, o_s_data, i_s_data;
  logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
  logic        o_s_we, o_s_stb, o_s_cyc, i_s_ack;
  logic [3:0]  o_s_sel;
  logic [1:0]  o_grant;

  int n_tests = 0;
  int n_fail  = 0;

  wb_bus_arbiter #(.N_ADDR(32), .N_DATA(32), .TIMEOUT_CYC(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_addr(i_m0_addr), .i_m0_data(i_m0_data), .i_m0_we(i_m0_we), .i_m0_sel(i_m0_sel),
    .i_m0_stb(i_m0_stb), .i_m0_cyc(i_m0_cyc),
    .i_m1_addr(i_m1_addr), .i_m1_data(i_m1_data), .i_m1_we(i_m1_we), .i_m1_sel(i_m1_sel),
    .i_m1_stb(i_m1_stb), .i_m1_cyc(i_m1_cyc),
    .o_m0_data(o_m0_data), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
    .o_m1_data(o_m1_data), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
    .o_s_addr(o_s_addr), .o_s_data(o_s_data), .o_s_we(o_s_we), .o_s_sel(o_s_sel),
    .o_s_stb(o_s_stb), .o_s_cyc(o_s_cyc),
    .i_s_data(i_s_data), .i_s_ack(i_s_ack),
    .o_grant(o_grant)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic [4:0]  in_bits;   // {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack}
    logic [31:0] s_data;
    logic [1:0]  grant;
    logic [3:0]  out_bits;  // {s_cyc, s_stb, m0_ack, m1_ack}
    logic [31:0] s_addr;
    logic [31:0] m0_data;
    logic [31:0] m1_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input logic [4:0] ib, input logic [31:0] sd,
                              input logic [1:0] g, input logic [3:0] ob, input logic [31:0] a,
                              input logic [31:0] d0, input logic [31:0] d1);
    vec_t v;
    v.name = nm; v.in_bits = ib; v.s_data = sd; v.grant = g; v.out_bits = ob;
    v.s_addr = a; v.m0_data = d0; v.m1_data = d1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [7:0] ctrl_now();
    return {o_grant, o_s_cyc, o_s_stb, o_m0_ack, o_m1_ack, o_m0_err, o_m1_err};
  endfunction

  initial begin
    i_rst = 1'b1;
    i_m0_addr = 32'h0000_0010; i_m0_data = 32'h0; i_m0_we = 1'b0; i_m0_sel = 4'hF;
    i_m1_addr = 32'h0000_0020; i_m1_data = 32'h0; i_m1_we = 1'b0; i_m1_sel = 4'hF;
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m1_cyc = 1'b0; i_m1_stb = 1'b0;
    i_s_ack = 1'b1; i_s_data = 32'h5A5A_5A5A;

    // Requests and a stray ack while reset is held must leave every output at 0.
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset_ctrl", ctrl_now(), 8'h00);
    chk("reset_slave", {o_s_addr, o_s_data, o_s_we, o_s_sel}, 69'h0);
    chk("reset_mdata", {o_m0_data, o_m1_data}, 64'h0);
    i_m0_cyc = 1'b0; i_m0_stb = 1'b0; i_s_ack = 1'b0; i_s_data = 32'h0;
    tick();
    i_rst = 1'b0;

    vecs.push_back(mk("idle",        5'b00000, 32'h0,         2'b00, 4'b0000, 32'h0,  32'h0, 32'h0));
    vecs.push_back(mk("stray_ack",   5'b00001, 32'hAAAA_5555, 2'b00, 4'b0000, 32'h0,  32'h0, 32'h0));
    vecs.push_back(mk("stray_after", 5'b00000, 32'h0,         2'b00, 4'b0000, 32'h0,  32'h0, 32'h0));
    vecs.push_back(mk("tie1_req",    5'b11110, 32'h0,         2'b00, 4'b0000, 32'h0,  32'h0, 32'h0));
    vecs.push_back(mk("tie1_m0",     5'b11111, 32'h1111_0000, 2'b01, 4'b1110, 32'h10, 32'h1111_0000, 32'h0));
    vecs.push_back(mk("tie1_drop",   5'b00110, 32'h0,         2'b01, 4'b0000, 32'h0,  32'h0, 32'h0));
    vecs.push_back(mk("tie2_idle",   5'b11110, 32'h0,         2'b00, 4'b0000, 32'h0,  32'h0, 32'h0));
    vecs.push_back(mk("tie2_m1",     5'b11111, 32'h2222_0000, 2'b10, 4'b1101, 32'h20, 32'h0, 32'h2222_0000));
    vecs.push_back(mk("tie2_drop",   5'b11000, 32'h0,         2'b10, 4'b0000, 32'h0,  32'h0, 32'h0));
    vecs.push_back(mk("tie3_idle",   5'b11110, 32'h0,         2'b00, 4'b0000, 32'h0,  32'h0, 32'h0));
    vecs.push_back(mk("tie3_m0",     5'b11110, 32'h0,         2'b01, 4'b1100, 32'h10, 32'h0, 32'h0));
    vecs.push_back(mk("tie3_drop",   5'b00110, 32'h0,         2'b01, 4'b0000, 32'h0,  32'h0, 32'h0));
    vecs.push_back(mk("tie4_idle",   5'b11110, 32'h0,         2'b00, 4'b0000, 32'h0,  32'h0, 32'h0));
    vecs.push_back(mk("tie4_m1",     5'b11110, 32'h0,         2'b10, 4'b1100, 32'h20, 32'h0, 32'h0));
    vecs.push_back(mk("tie4_drop",   5'b00000, 32'h0,         2'b10, 4'b0000, 32'h0,  32'h0, 32'h0));
    vecs.push_back(mk("post_idle",   5'b00000, 32'h0,         2'b00, 4'b0000, 32'h0,  32'h0, 32'h0));
    vecs.push_back(mk("rd_req",      5'b11000, 32'h0,         2'b00, 4'b0000, 32'h0,  32'h0, 32'h0));
    vecs.push_back(mk("rd_wait1",    5'b11000, 32'h0,         2'b01, 4'b1100, 32'h10, 32'h0, 32'h0));
    vecs.push_back(mk("rd_wait2",    5'b11000, 32'h0,         2'b01, 4'b1100, 32'h10, 32'h0, 32'h0));
    vecs.push_back(mk("rd_ack",      5'b11001, 32'h2402_0001, 2'b01, 4'b1110, 32'h10, 32'h2402_0001, 32'h0));
    vecs.push_back(mk("rd_drop",     5'b00000, 32'h0,         2'b01, 4'b0000, 32'h0,  32'h0, 32'h0));
    vecs.push_back(mk("rd_idle",     5'b00000, 32'h0,         2'b00, 4'b0000, 32'h0,  32'h0, 32'h0));

    foreach (vecs[i]) begin
      {i_m0_cyc, i_m0_stb, i_m1_cyc, i_m1_stb, i_s_ack} = vecs[i].in_bits;
      i_s_data = vecs[i].s_data;
      @(negedge i_clk);
      chk({vecs[i].name, "_ctrl"}, ctrl_now(), {vecs[i].grant, vecs[i].out_bits, 2'b00});
      chk({vecs[i].name, "_mdata"}, {o_m0_data, o_m1_data}, {vecs[i].m0_data, vecs[i].m1_data});
      if (vecs[i].grant == 2'b00 || vecs[i].out_bits[3])
        chk({vecs[i].name, "_addr"}, o_s_addr, vecs[i].s_addr);
      tick();
    end

    // m1 write burst; m0 requests mid-burst and must wait for m1 to release cyc.
    i_m1_we = 1'b1; i_m1_sel = 4'b0011; i_m1_data = 32'hDEAD_BEEF; i_m1_addr = 32'h100;
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1; i_s_ack = 1'b0;
    @(negedge i_clk);
    chk("burst_arb_idle", ctrl_now(), 8'h00);
    tick();
    for (int b = 0; b < 4; b++) begin
      i_m1_addr = 32'h100 + 32'(4 * b);
      i_s_ack = 1'b1;
      if (b == 1) begin
        i_m0_cyc = 1'b1; i_m0_stb = 1'b1;
      end
      @(negedge i_clk);
      chk($sformatf("burst_beat%0d_ctrl", b), ctrl_now(), 8'b10_11_01_00);
      chk($sformatf("burst_beat%0d_bus", b), {o_s_addr, o_s_data, o_s_we, o_s_sel},
          {32'h100 + 32'(4 * b), 32'hDEAD_BEEF, 1'b1, 4'b0011});
      tick();
    end
    i_m1_cyc = 1'b0; i_m1_stb = 1'b0; i_s_ack = 1'b0; i_m1_we = 1'b0;
    @(negedge i_clk);
    chk("burst_release", ctrl_now(), 8'b10_00_00_00);
    tick();
    @(negedge i_clk);
    chk("burst_gap_idle", ctrl_now(), 8'h00);
    tick();
    @(negedge i_clk);
    chk("burst_m0_after", ctrl_now(), 8'b01_11_00_00);
    chk("burst_m0_bus", {o_s_addr, o_s_we, o_s_sel}, {32'h10, 1'b0, 4'hF});
    i_m0_cyc = 1'b0; i_m0_stb = 1'b0;
    tick();
    tick();

    // Watchdog: m1 strobes with no ack; err on the 8th strobe cycle, then the count restarts.
    i_m1_addr = 32'h20; i_m1_sel = 4'hF;
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1;
    @(negedge i_clk);
    chk("to_arb_idle", ctrl_now(), 8'h00);
    tick();
    for (int k = 1; k <= 10; k++) begin
      @(negedge i_clk);
      if (k == 8) chk("to_hit", ctrl_now(), 8'b10_10_00_01);
      else        chk($sformatf("to_wait%0d", k), ctrl_now(), 8'b10_11_00_00);
      tick();
    end
    // An ack on the count-limit cycle of the second window wins over the timeout.
    for (int k = 11; k <= 16; k++) begin
      i_s_ack = (k == 16);
      @(negedge i_clk);
      if (k == 16) chk("to_ack_wins", ctrl_now(), 8'b10_11_01_00);
      tick();
    end
    i_s_ack = 1'b0; i_m1_cyc = 1'b0; i_m1_stb = 1'b0;
    tick();
    tick();

    // Async reset mid-transfer, then the first tie after release must go to m0.
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1;
    tick();
    @(negedge i_clk);
    chk("rst_pre_own", ctrl_now(), 8'b01_11_00_00);
    @(posedge i_clk);
    #2;
    i_s_ack = 1'b1;
    i_rst = 1'b1;
    #1;
    chk("rst_async_drop", ctrl_now(), 8'h00);
    i_s_ack = 1'b0;
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1;
    tick();
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_post_idle", ctrl_now(), 8'h00);
    tick();
    @(negedge i_clk);
    chk("rst_tie_m0", ctrl_now(), 8'b01_11_00_00);
    i_m0_cyc = 1'b0; i_m0_stb = 1'b0; i_m1_cyc = 1'b0; i_m1_stb = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
